seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller. It drives DIGITS common-anode digits from one packed hex/BCD value, adding several features over the fixed two-nibble scanner: tear-free frame-synchronous data update, leading-zero blanking, per-digit decimal points and per-digit blinking. It sits between counter/FSM logic such as a washing-machine timer and the board's segment and digit-select pins.

## Interface
- DIGITS, 4: number of multiplexed digits, legal 1..8.
- SCAN_DIV, 100000: CP cycles per digit slot, legal ≥ 2.
- BLINK_FRAMES, 64: full scan frames per blink half-period, legal ≥ 1.
- CP, in, 1: system clock. All logic is on the rising edge.
- nCR, in, 1: reset, synchronous, active-low.
- value, in, 4·DIGITS: nibble k (bits 4k+3:4k) is shown on digit k. Digit 0 is least significant.
- load, in, 1: captures value, dp and blink_en into the shadow registers.
- dp, in, DIGITS: decimal point enable per digit, active-high.
- blink_en, in, DIGITS: blink enable per digit, active-high.
- lzb, in, 1: leading-zero blanking enable, level-sensitive, sampled each slot.
- oSEG, out, 7: {g,f,e,d,c,b,a}, active-low.
- oDP, out, 1: decimal point, active-low.
- light, out, DIGITS: digit select, active-low, one-cold.
- frame_start, out, 1: one-cycle pulse when the display registers update.

## Operation
- Divider counts 0..SCAN_DIV−1. A tick occurs when it equals SCAN_DIV−1, and it then wraps to 0.
- On each tick, pointer ptr advances by 1 and wraps from DIGITS−1 to 0.
- A frame boundary is a tick on which ptr wraps to 0. On a frame boundary:
  - the shadow registers copy into the display registers;
  - frame_start pulses;
  - the blink frame counter advances.
- When the blink frame counter reaches BLINK_FRAMES−1 it wraps to 0 and blink_phase toggles.
- When load=1, the shadow registers take value, dp and blink_en.
- Load is accepted on any cycle, and the last load before a frame boundary wins.
- Digit k is blanked (oSEG=7'h7F, oDP=1) when either condition holds:
  - blink_phase=1 and display blink_en[k]=1;
  - lzb=1, k≠0, and display nibbles k..DIGITS−1 are all zero.
- Digit 0 is never blanked by lzb.
- Otherwise oSEG shows the hex glyph of nibble k, and oDP = ~dp[k].
- Hex glyphs, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=18, A=08, b=03, C=46, d=21, E=06, F=0E
- light[ptr]=0 and all other bits are 1, including while the digit is blanked.

## Timing
- oSEG, oDP, light and frame_start are registered, and there is no combinational path from any input to any output.
- Outputs reflect ptr and the display registers with 1 cycle of latency.
- When nCR=0 at a clock edge, on that edge:
  - divider, ptr, blink counter and blink_phase clear to 0;
  - shadow and display registers clear to 0;
  - light=all 1s, oSEG=7'h7F, oDP=1, frame_start=0.
- First cycle after nCR returns high: outputs show digit 0 (glyph 0 with lzb=0), and light=~1.
- No frame_start occurs at reset release. The first frame_start comes DIGITS·SCAN_DIV cycles later.
- If load coincides with a frame boundary:
  - display takes the old shadow;
  - the new value appears at the next frame boundary.
- Reset asserted mid-frame or mid-load: everything returns to reset values on that edge, and a pending load is discarded.
- DIGITS=1: every tick is a frame boundary and light is always 0 after reset.

## Structure
- Package seg7_pkg holds:
  - the 16-entry glyph constants;
  - SEG_BLANK = 7'h7F;
  - a function for the one-cold digit-select pattern.
- Sub-module seg7_hex_decode (4-bit in, 7-bit active-low out) is combinational and is instantiated once on the muxed nibble.
- The top holds the divider, ptr, blink counter, shadow/display registers, blanking logic and output registers.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
- **Reset:** hold nCR=0 3 cycles → light=4'hF, oSEG=7'h7F, oDP=1. Release → next cycle light=4'b1110, oSEG=7'h40. First frame_start 16 cycles after release.
- **Scan and decode:** load value=16'h2E79 once, then wait one frame → digits 0..3 show 7'h18, 7'h78, 7'h06, 7'h24. Each slot lasts 4 cycles, and light cycles 1110→1101→1011→0111→1110.
- **Frame-synchronous update:** during a frame, load 16'h1234, then 16'h5678 in a later cycle → the next frame shows only 5678. Load exactly on the frame_start cycle → that value appears one frame later.
- **Leading-zero blanking:** value=16'h0050, lzb=1 → digits 3 and 2 blanked (7'h7F), digit 1 shows 7'h12, digit 0 shows 7'h40. value=16'h0000 → only digit 0 is lit.
- **Blink and dp:**
  - blink_en=4'b0100, dp=4'b0001 → digit 2 lit for 2 frames then blanked for 2 frames, repeating.
  - oDP=0 only in digit 0 slots.
  - Other digits are unaffected.
- **Mid-operation reset:** assert nCR=0 for one cycle during slot 2 with a load pending → all outputs return to reset values, and the display shows 0000 afterwards.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display controller.
package seg7_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs, entry n is hex digit n.
  localparam logic [15:0][SEG_W-1:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [MAX_DIGITS-1:0] one_cold(input logic [2:0] idx);
    return ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = SEG_GLYPH[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with frame-synchronous update,
// leading-zero blanking, per-digit decimal points and per-digit blinking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                CP,
  input  logic                nCR,
  input  logic [4*DIGITS-1:0] value,
  input  logic                load,
  input  logic [DIGITS-1:0]   dp,
  input  logic [DIGITS-1:0]   blink_en,
  input  logic                lzb,
  output logic [SEG_W-1:0]    oSEG,
  output logic                oDP,
  output logic [DIGITS-1:0]   light,
  output logic                frame_start
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DW-1:0]     div_q;
  logic [PW-1:0]     ptr_q;
  logic [BW-1:0]     bcnt_q;
  logic              blink_phase_q;

  logic [VW-1:0]     shadow_value_q;
  logic [DIGITS-1:0] shadow_dp_q;
  logic [DIGITS-1:0] shadow_blink_q;
  logic [VW-1:0]     disp_value_q;
  logic [DIGITS-1:0] disp_dp_q;
  logic [DIGITS-1:0] disp_blink_q;

  logic              tick_c;
  logic              wrap_c;
  logic [3:0]        nib_c;
  logic              dp_sel_c;
  logic              blink_sel_c;
  logic              lz_sel_c;
  logic              blank_c;
  logic [DIGITS-1:0] lz_blank_c;
  logic [SEG_W-1:0]  glyph_c;

  assign tick_c = (div_q == DW'(SCAN_DIV - 1));
  assign wrap_c = tick_c && (ptr_q == PW'(DIGITS - 1));

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin : lz_scan
    logic all_zero;
    all_zero   = 1'b1;
    lz_blank_c = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero      = all_zero && (disp_value_q[4*k +: 4] == 4'h0);
      lz_blank_c[k] = lzb && all_zero && (k != 0);
    end
  end

  // Select the attributes of the digit currently being scanned.
  always_comb begin
    nib_c       = 4'h0;
    dp_sel_c    = 1'b0;
    blink_sel_c = 1'b0;
    lz_sel_c    = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (ptr_q == PW'(k)) begin
        nib_c       = disp_value_q[4*k +: 4];
        dp_sel_c    = disp_dp_q[k];
        blink_sel_c = disp_blink_q[k];
        lz_sel_c    = lz_blank_c[k];
      end
    end
  end

  assign blank_c = (blink_phase_q && blink_sel_c) || lz_sel_c;

  seg7_hex_decode u_dec (
    .hex   (nib_c),
    .seg_c (glyph_c)
  );

  always_ff @(posedge CP) begin
    if (!nCR) begin
      div_q          <= '0;
      ptr_q          <= '0;
      bcnt_q         <= '0;
      blink_phase_q  <= 1'b0;
      shadow_value_q <= '0;
      shadow_dp_q    <= '0;
      shadow_blink_q <= '0;
      disp_value_q   <= '0;
      disp_dp_q      <= '0;
      disp_blink_q   <= '0;
      light          <= '1;
      oSEG           <= SEG_BLANK;
      oDP            <= 1'b1;
      frame_start    <= 1'b0;
    end else begin
      div_q <= tick_c ? '0 : div_q + DW'(1);
      if (tick_c) begin
        ptr_q <= wrap_c ? '0 : ptr_q + PW'(1);
      end

      if (load) begin
        shadow_value_q <= value;
        shadow_dp_q    <= dp;
        shadow_blink_q <= blink_en;
      end

      // Display only changes on a frame boundary so a frame is never torn.
      if (wrap_c) begin
        disp_value_q <= shadow_value_q;
        disp_dp_q    <= shadow_dp_q;
        disp_blink_q <= shadow_blink_q;
        if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
          bcnt_q        <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          bcnt_q <= bcnt_q + BW'(1);
        end
      end

      light       <= DIGITS'(one_cold(3'(ptr_q)));
      oSEG        <= blank_c ? SEG_BLANK : glyph_c;
      oDP         <= blank_c || !dp_sel_c;
      frame_start <= wrap_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seg7_scan_ctrl;

  logic        CP = 1'b0;
  logic        nCR;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp;
  logic [3:0]  blink_en;
  logic        lzb;
  logic [6:0]  oSEG;
  logic        oDP;
  logic [3:0]  light;
  logic        frame_start;

  int tests = 0;
  int fails = 0;
  logic [11:0] sb_q[$];

  seg7_scan_ctrl #(
    .DIGITS       (4),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .CP          (CP),
    .nCR         (nCR),
    .value       (value),
    .load        (load),
    .dp          (dp),
    .blink_en    (blink_en),
    .lzb         (lzb),
    .oSEG        (oSEG),
    .oDP         (oDP),
    .light       (light),
    .frame_start (frame_start)
  );

  always #5 CP = ~CP;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input logic [6:0] s3, input logic [3:0] dpn, input int n);
    logic [6:0] segs [4];
    logic [3:0] lights [4];
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    lights[0] = 4'b1110; lights[1] = 4'b1101; lights[2] = 4'b1011; lights[3] = 4'b0111;
    for (int k = 0; k < n; k++) sb_q.push_back({lights[k], segs[k], dpn[k]});
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CP);
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blink_en = b; load = 1'b1;
    @(negedge CP);
    load = 1'b0;
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge CP);
      n++;
    end while (!frame_start && n < 40);
    if (!frame_start) begin
      tests++;
      fails++;
      $display("FAIL fs_timeout: actual no frame_start required frame_start within 40 cycles");
    end
  endtask

  // Release reset, check the first output cycle and the distance to the first frame_start.
  task automatic release_wait(input bit do_load, input logic [15:0] v);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    nCR = 1'b1;
    while (n < 40 && !seen) begin
      @(negedge CP);
      n++;
      if (n == 1) begin
        check("rel_light", light, 4'b1110);
        check("rel_seg", oSEG, 7'h40);
        check("rel_dp", oDP, 1'b1);
      end
      if (do_load && n == 3) begin
        value = v;
        load  = 1'b1;
      end
      if (n == 4) load = 1'b0;
      if (frame_start) seen = 1'b1;
    end
    check("first_fs_delay", n, 16);
  endtask

  task automatic check_reset_outputs();
    check("rst_light", light, 4'hF);
    check("rst_seg", oSEG, 7'h7F);
    check("rst_dp", oDP, 1'b1);
    check("rst_fs", frame_start, 1'b0);
  endtask

  // Monitor: each new digit slot pops one expected {light, oSEG, oDP} and checks slot length.
  initial begin : monitor
    logic [3:0]  prev_light;
    logic [11:0] exp_slot;
    int          run;
    bit          slot_ok;
    prev_light = 4'hF;
    run        = 0;
    slot_ok    = 1'b0;
    forever begin
      @(negedge CP);
      run++;
      if (light !== prev_light) begin
        if (sb_q.size() != 0) begin
          exp_slot = sb_q.pop_front();
          check("slot", {light, oSEG, oDP}, exp_slot);
          if (slot_ok) check("slot_len", run, 4);
        end
        slot_ok    = (prev_light != 4'hF) && (light != 4'hF);
        prev_light = light;
        run        = 0;
      end
    end
  end

  initial begin : stimulus
    nCR = 1'b0; load = 1'b0; value = '0; dp = '0; blink_en = '0; lzb = 1'b0;
    wait_neg(3);
    check_reset_outputs();

    // F1: 2E79 loaded during the first frame.
    release_wait(1'b1, 16'h2E79);
    push_frame(7'h18, 7'h78, 7'h06, 7'h24, 4'b1111, 4);
    wait_neg(2);
    drive_load(16'h1234, 4'b0000, 4'b0000);
    wait_neg(3);
    drive_load(16'h5678, 4'b0000, 4'b0000);

    // F2: last load wins; load ABCD on the frame_start cycle, 1357 on the boundary edge.
    wait_fs();
    push_frame(7'h00, 7'h78, 7'h02, 7'h12, 4'b1111, 4);
    value = 16'hABCD; load = 1'b1;
    @(negedge CP);
    load = 1'b0;
    wait_neg(14);
    value = 16'h1357; load = 1'b1;
    wait_fs();
    load = 1'b0;

    // F3: boundary load was not taken yet.
    push_frame(7'h21, 7'h46, 7'h03, 7'h08, 4'b1111, 4);

    wait_fs();
    push_frame(7'h78, 7'h12, 7'h30, 7'h79, 4'b1111, 4);
    wait_neg(2);
    lzb = 1'b1;
    drive_load(16'h0050, 4'b0000, 4'b0000);

    wait_fs();
    push_frame(7'h40, 7'h12, 7'h7F, 7'h7F, 4'b1111, 4);
    wait_neg(2);
    drive_load(16'h0000, 4'b0000, 4'b0000);

    wait_fs();
    push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b1111, 4);
    wait_neg(2);
    drive_load(16'h4321, 4'b0001, 4'b0100);

    // Blink phase over frames 7..11 is 1,0,0,1,1.
    wait_fs();
    push_frame(7'h79, 7'h24, 7'h7F, 7'h19, 4'b1110, 4);
    wait_fs();
    push_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'b1110, 4);
    wait_fs();
    push_frame(7'h79, 7'h24, 7'h30, 7'h19, 4'b1110, 4);
    wait_fs();
    push_frame(7'h79, 7'h24, 7'h7F, 7'h19, 4'b1110, 4);
    wait_fs();
    push_frame(7'h79, 7'h24, 7'h7F, 7'h19, 4'b1110, 3);

    // Mid-frame reset during slot 2 with a load pending in the shadow registers.
    wait_neg(5);
    drive_load(16'h9999, 4'b1111, 4'b0000);
    wait_neg(3);
    nCR = 1'b0;
    lzb = 1'b0;
    @(negedge CP);
    check_reset_outputs();
    release_wait(1'b0, 16'h0000);
    push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b1111, 4);
    wait_fs();

    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
